// File: rtl/exe_mc.sv
// exe_mc -- multi-cycle execute stage (between ID and MEM).
//
// Single-cycle ALU operations complete in the cycle EXE_valid is seen.
// MULT/MULTU use an iterative shift-add multiplier. DIV/DIVU use an
// iterative restoring divider. Both write the architectural HI/LO registers.
// MFHI/MFLO read HI/LO back as the execute result.
//
// Optional feature macro: EXE_DIV_EN
//   defined   -> the divider datapath is built
//   undefined -> DIV/DIVU complete in one cycle with result 0 and leave HI/LO
//                untouched
//
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   EXE_valid      stage active (level, held until EXE_over is seen)
//   ID_EXE_bus_r   {alu_control, alu_operand1, alu_operand2, md_op,
//                   mem_control, store_data, rf_wen, rf_wdest, pc}
//   EXE_over       stage done for the current instruction
//   EXE_MEM_bus    {mem_control, store_data, exe_result, rf_wen, rf_wdest, pc}
//   EXE_pc         pc field, for display
//   EXE_md_busy    high while the mul/div engine is iterating
module exe_mc #(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 12,
    parameter int MEM_CTRL_W = 4,
    parameter int PC_W       = 32
) (
    input  logic                                                   clk,
    input  logic                                                   resetn,
    input  logic                                                   EXE_valid,
    input  logic [ALU_CTRL_W+2*XLEN+3+MEM_CTRL_W+XLEN+6+PC_W-1:0] ID_EXE_bus_r,
    output logic                                                   EXE_over,
    output logic [MEM_CTRL_W+2*XLEN+6+PC_W-1:0]                    EXE_MEM_bus,
    output logic [PC_W-1:0]                                        EXE_pc,
    output logic                                                   EXE_md_busy
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MFHI  = 3'b101;
    localparam logic [2:0] MD_MFLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    // Conditional two's complement negate, datapath width.
    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
        cneg = neg ? -v : v;
    endfunction

    // Conditional two's complement negate, double width.
    function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic neg);
        cneg2 = neg ? -v : v;
    endfunction

    // ID->EXE bus fields
    logic [ALU_CTRL_W-1:0] alu_control_s;
    logic [XLEN-1:0]       alu_operand1_s;
    logic [XLEN-1:0]       alu_operand2_s;
    logic [2:0]            md_op_s;
    logic [MEM_CTRL_W-1:0] mem_control_s;
    logic [XLEN-1:0]       store_data_s;
    logic                  rf_wen_s;
    logic [4:0]            rf_wdest_s;
    logic [PC_W-1:0]       pc_s;

    assign {alu_control_s, alu_operand1_s, alu_operand2_s, md_op_s, mem_control_s,
            store_data_s, rf_wen_s, rf_wdest_s, pc_s} = ID_EXE_bus_r;

    logic [XLEN-1:0]   alu_result_s;
    logic [XLEN-1:0]   exe_result_s;
    logic [CNT_W-1:0]  sh_amt_s;

    md_state_e         state_r;
    md_state_e         state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   opnd_r;
    logic              res_neg_r;
    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;

    logic              is_md_s;
    logic              signed_s;
    logic              start_s;
    logic              finish_s;
    logic              over_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic [2*XLEN-1:0] start_acc_s;
    logic [XLEN-1:0]   start_opnd_s;
    logic              start_neg_s;
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_step_s;
    logic [2*XLEN-1:0] acc_step_s;
    logic [XLEN-1:0]   fin_hi_s;
    logic [XLEN-1:0]   fin_lo_s;

`ifdef EXE_DIV_EN
    logic              div_s;
    logic              is_div_r;
    logic              rem_neg_r;
    logic [XLEN:0]     div_upper_s;
    logic [XLEN-1:0]   div_diff_s;
    logic [2*XLEN-1:0] div_step_s;
`endif

    assign sh_amt_s = alu_operand1_s[CNT_W-1:0];

    // One-hot ALU: {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}, MSB first.
    always_comb begin
        alu_result_s = {XLEN{1'b0}};
        if (alu_control_s[11]) begin
            alu_result_s = alu_operand1_s + alu_operand2_s;
        end else if (alu_control_s[10]) begin
            alu_result_s = alu_operand1_s - alu_operand2_s;
        end else if (alu_control_s[9]) begin
            alu_result_s = {{(XLEN-1){1'b0}}, ($signed(alu_operand1_s) < $signed(alu_operand2_s))};
        end else if (alu_control_s[8]) begin
            alu_result_s = {{(XLEN-1){1'b0}}, (alu_operand1_s < alu_operand2_s)};
        end else if (alu_control_s[7]) begin
            alu_result_s = alu_operand1_s & alu_operand2_s;
        end else if (alu_control_s[6]) begin
            alu_result_s = ~(alu_operand1_s | alu_operand2_s);
        end else if (alu_control_s[5]) begin
            alu_result_s = alu_operand1_s | alu_operand2_s;
        end else if (alu_control_s[4]) begin
            alu_result_s = alu_operand1_s ^ alu_operand2_s;
        end else if (alu_control_s[3]) begin
            alu_result_s = alu_operand2_s << sh_amt_s;
        end else if (alu_control_s[2]) begin
            alu_result_s = alu_operand2_s >> sh_amt_s;
        end else if (alu_control_s[1]) begin
            alu_result_s = $signed(alu_operand2_s) >>> sh_amt_s;
        end else if (alu_control_s[0]) begin
            alu_result_s = alu_operand2_s << 5'd16;
        end else begin
            alu_result_s = {XLEN{1'b0}};
        end
    end

    // Decode which md_op values start the iterative engine.
    always_comb begin
        is_md_s  = 1'b0;
        signed_s = 1'b0;
`ifdef EXE_DIV_EN
        div_s    = 1'b0;
`endif
        case (md_op_s)
            MD_MULT: begin
                is_md_s  = 1'b1;
                signed_s = 1'b1;
            end
            MD_MULTU: begin
                is_md_s  = 1'b1;
            end
`ifdef EXE_DIV_EN
            MD_DIV: begin
                is_md_s  = 1'b1;
                signed_s = 1'b1;
                div_s    = 1'b1;
            end
            MD_DIVU: begin
                is_md_s  = 1'b1;
                div_s    = 1'b1;
            end
`endif
            default: begin
                is_md_s  = 1'b0;
            end
        endcase
    end

    // Operand magnitudes and result sign captured at the start edge.
    // A zero divisor never negates the all-ones quotient.
    always_comb begin
        a_neg_s      = signed_s & alu_operand1_s[XLEN-1];
        b_neg_s      = signed_s & alu_operand2_s[XLEN-1];
        a_mag_s      = cneg(alu_operand1_s, a_neg_s);
        b_mag_s      = cneg(alu_operand2_s, b_neg_s);
        start_acc_s  = {{XLEN{1'b0}}, b_mag_s};
        start_opnd_s = a_mag_s;
        start_neg_s  = a_neg_s ^ b_neg_s;
`ifdef EXE_DIV_EN
        if (div_s) begin
            start_acc_s  = {{XLEN{1'b0}}, a_mag_s};
            start_opnd_s = b_mag_s;
            start_neg_s  = (a_neg_s ^ b_neg_s) & (|alu_operand2_s);
        end else begin
            start_acc_s  = {{XLEN{1'b0}}, b_mag_s};
            start_opnd_s = a_mag_s;
            start_neg_s  = a_neg_s ^ b_neg_s;
        end
`endif
    end

    // Shift-add step: add multiplicand into the upper half when the LSB is set, then shift right.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
        end
        mul_step_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end

`ifdef EXE_DIV_EN
    // Restoring divide step: the shifted partial remainder needs XLEN+1 bits for the compare.
    always_comb begin
        div_upper_s = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s  = div_upper_s[XLEN-1:0] - opnd_r;
        if (div_upper_s >= {1'b0, opnd_r}) begin
            div_step_s = {div_diff_s, acc_r[XLEN-2:0], 1'b1};
        end else begin
            div_step_s = {acc_r[2*XLEN-2:0], 1'b0};
        end
    end
`endif

    // Select the engine step and form the signed HI/LO values of the final iteration.
    always_comb begin
        acc_step_s = mul_step_s;
        {fin_hi_s, fin_lo_s} = cneg2(mul_step_s, res_neg_r);
`ifdef EXE_DIV_EN
        if (is_div_r) begin
            acc_step_s = div_step_s;
            fin_lo_s   = cneg(div_step_s[XLEN-1:0], res_neg_r);
            fin_hi_s   = cneg(div_step_s[2*XLEN-1:XLEN], rem_neg_r);
        end else begin
            acc_step_s = mul_step_s;
            {fin_hi_s, fin_lo_s} = cneg2(mul_step_s, res_neg_r);
        end
`endif
    end

    // FSM next state and completion handshake.
    always_comb begin
        state_s  = state_r;
        start_s  = 1'b0;
        finish_s = 1'b0;
        over_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (EXE_valid && is_md_s) begin
                    start_s = 1'b1;
                    state_s = ST_BUSY;
                end else begin
                    over_s  = EXE_valid;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_W'(XLEN-1)) begin
                    finish_s = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    state_s  = ST_BUSY;
                end
            end
            ST_DONE: begin
                over_s = EXE_valid;
                if (!EXE_valid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Iteration counter, accumulator, latched operand and result sign.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            opnd_r    <= {XLEN{1'b0}};
            res_neg_r <= 1'b0;
        end else if (start_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= start_acc_s;
            opnd_r    <= start_opnd_s;
            res_neg_r <= start_neg_s;
        end else if (state_r == ST_BUSY) begin
            cnt_r     <= cnt_r + CNT_W'(1);
            acc_r     <= acc_step_s;
        end else begin
            cnt_r     <= cnt_r;
            acc_r     <= acc_r;
        end
    end

`ifdef EXE_DIV_EN
    // Divide-specific flags captured at the start edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_div_r  <= 1'b0;
            rem_neg_r <= 1'b0;
        end else if (start_s) begin
            is_div_r  <= div_s;
            rem_neg_r <= a_neg_s;
        end else begin
            is_div_r  <= is_div_r;
            rem_neg_r <= rem_neg_r;
        end
    end
`endif

    // Architectural HI/LO, written on the edge that enters DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_r <= {XLEN{1'b0}};
            lo_r <= {XLEN{1'b0}};
        end else if (finish_s) begin
            hi_r <= fin_hi_s;
            lo_r <= fin_lo_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Execute result select; reserved md_op behaves as none.
    always_comb begin
        exe_result_s = alu_result_s;
        case (md_op_s)
            MD_NONE:  exe_result_s = alu_result_s;
            MD_MFHI:  exe_result_s = hi_r;
            MD_MFLO:  exe_result_s = lo_r;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: exe_result_s = {XLEN{1'b0}};
            default:  exe_result_s = alu_result_s;
        endcase
    end

    assign EXE_over    = resetn & over_s;
    assign EXE_md_busy = (state_r == ST_BUSY);
    assign EXE_pc      = pc_s;
    assign EXE_MEM_bus = {mem_control_s, store_data_s, exe_result_s, rf_wen_s, rf_wdest_s, pc_s};

endmodule

// File: tb/tb_exe_mc.sv
module tb_exe_mc;
    localparam int XLEN = 32;
`ifdef EXE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         EXE_valid = 1'b0;
    logic [11:0]  f_ctrl = 12'h800;
    logic [31:0]  f_a = 32'd0, f_b = 32'd0, f_sd = 32'd0, f_pc = 32'd0;
    logic [2:0]   f_md = 3'd0;
    logic [3:0]   f_memc = 4'd0;
    logic         f_wen = 1'b0;
    logic [4:0]   f_wd = 5'd0;
    logic [152:0] id_bus;
    logic         EXE_over, EXE_md_busy;
    logic [105:0] exe_mem_bus;
    logic [31:0]  exe_pc;

    int n_total = 0;
    int n_bad = 0;

    assign id_bus = {f_ctrl, f_a, f_b, f_md, f_memc, f_sd, f_wen, f_wd, f_pc};

    exe_mc dut (
        .clk(clk), .resetn(resetn), .EXE_valid(EXE_valid), .ID_EXE_bus_r(id_bus),
        .EXE_over(EXE_over), .EXE_MEM_bus(exe_mem_bus), .EXE_pc(exe_pc), .EXE_md_busy(EXE_md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_multi(input logic [2:0] md);
        return (md == 3'd1) || (md == 3'd2) || (DIV_EN && ((md == 3'd3) || (md == 3'd4)));
    endfunction

    // returns {hi, lo}
    function automatic logic [63:0] md_ref(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = 64'd0;
        case (md)
            3'd1: p = sa * sb;
            3'd2: p = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            end
            3'd4: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [11:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 12; i++) begin
            if (ctrl[11-i]) begin
                case (i)
                    0: return a + b;
                    1: return a - b;
                    2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3: return (a < b) ? 32'd1 : 32'd0;
                    4: return a & b;
                    5: return ~(a | b);
                    6: return a | b;
                    7: return a ^ b;
                    8: return b << a[4:0];
                    9: return b >> a[4:0];
                    10: return $signed(b) >>> a[4:0];
                    default: return {b[15:0], 16'h0000};
                endcase
            end
        end
        return 32'd0;
    endfunction

    // m_el: -1 idle, 1..XLEN iterating, XLEN+1 finished and waiting for valid to drop
    int          m_el = -1;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_el <= -1;
            m_hi <= 32'd0;
            m_lo <= 32'd0;
        end else if (m_el < 0) begin
            if (EXE_valid && is_multi(f_md)) begin
                m_el   <= 1;
                m_pend <= md_ref(f_md, f_a, f_b);
            end
        end else if (m_el <= XLEN) begin
            m_el <= m_el + 1;
            if (m_el == XLEN) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (!EXE_valid) begin
            m_el <= -1;
        end
    end

    logic [31:0] c_res;
    logic        c_over, c_busy;

    // every-cycle compare against the model
    always @(negedge clk) begin
        case (f_md)
            3'd5: c_res = m_hi;
            3'd6: c_res = m_lo;
            3'd1, 3'd2, 3'd3, 3'd4: c_res = 32'd0;
            default: c_res = alu_ref(f_ctrl, f_a, f_b);
        endcase
        c_over = resetn && EXE_valid && ((m_el < 0) ? !is_multi(f_md) : (m_el == XLEN + 1));
        c_busy = (m_el >= 1) && (m_el <= XLEN);
        chk("bus", exe_mem_bus, {f_memc, f_sd, c_res, f_wen, f_wd, f_pc});
        chk("over", EXE_over, c_over);
        chk("busy", EXE_md_busy, c_busy);
        chk("pc", exe_pc, f_pc);
    end

    // ---------------- stimulus ----------------
    task automatic do_op(input logic [11:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] md, input int extra, output int lat, output logic [31:0] res);
        bit done;
        f_ctrl = ctrl; f_a = a; f_b = b; f_md = md;
        f_memc = 4'($urandom); f_sd = $urandom; f_wen = 1'($urandom);
        f_wd = 5'($urandom); f_pc = $urandom;
        EXE_valid = 1'b1;
        lat = 0; res = 32'd0; done = 1'b0;
        while (!done && lat < 64) begin
            @(negedge clk);
            if (EXE_over) begin
                done = 1'b1;
                res = exe_mem_bus[69:38];
            end else begin
                lat++;
            end
        end
        if (!done) begin
            n_total++; n_bad++;
            $display("FAIL over_timeout md=%0d waited=%0d required_max=%0d", md, lat, XLEN);
        end
        repeat (extra) @(negedge clk);
        #1 EXE_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        int l;
        do_op(12'h020, $urandom, $urandom, 3'd5, 0, l, hi);
        chk("mfhi_lat", l, 0);
        do_op(12'h010, $urandom, $urandom, 3'd6, 0, l, lo);
        chk("mflo_lat", l, 0);
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] corners [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    int          lat, e_lat, k, extra;
    logic [31:0] res, hi, lo, e_hi, e_lo, ra, rb;
    logic [11:0] ctrl;
    logic [2:0]  md;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_over", EXE_over, 1'b0);
        chk("rst_busy", EXE_md_busy, 1'b0);
        #1 resetn = 1'b1;
        @(negedge clk); #1;

        // ADD 5 + 7
        do_op(12'h800, 32'd5, 32'd7, 3'd0, 0, lat, res);
        chk("add_lat", lat, 0);
        chk("add_res", res, 32'd12);
        chk("add_busy", EXE_md_busy, 1'b0);

        // MULT -1 * 2
        do_op(12'h800, 32'hFFFF_FFFF, 32'd2, 3'd1, 0, lat, res);
        chk("mult_over_cycle", lat + 1, 33);
        chk("mult_res", res, 32'd0);
        chk("model_hi_pin", m_hi, 32'hFFFF_FFFF);
        chk("model_lo_pin", m_lo, 32'hFFFF_FFFE);
        read_hilo(hi, lo);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        // MULTU same operands
        do_op(12'h800, 32'hFFFF_FFFF, 32'd2, 3'd2, 0, lat, res);
        chk("multu_lat", lat, XLEN);
        read_hilo(hi, lo);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // MULT 3 * -5, valid held 3 cycles past DONE
        do_op(12'h800, 32'd3, 32'hFFFF_FFFB, 3'd1, 3, lat, res);
        chk("hold_lat", lat, XLEN);
        read_hilo(hi, lo);
        chk("hold_hi", hi, 32'hFFFF_FFFF);
        chk("hold_lo", lo, 32'hFFFF_FFF1);

        // DIV -7 / 2
        do_op(12'h800, 32'hFFFF_FFF9, 32'd2, 3'd3, 0, lat, res);
`ifdef EXE_DIV_EN
        e_lat = XLEN; e_hi = 32'hFFFF_FFFF; e_lo = 32'hFFFF_FFFD;
`else
        e_lat = 0; e_hi = 32'hFFFF_FFFF; e_lo = 32'hFFFF_FFF1;
`endif
        chk("div_lat", lat, e_lat);
        chk("div_res", res, 32'd0);
        read_hilo(hi, lo);
        chk("div_hi", hi, e_hi);
        chk("div_lo", lo, e_lo);

        // DIVU 0x1234 / 0
        do_op(12'h800, 32'h0000_1234, 32'd0, 3'd4, 0, lat, res);
`ifdef EXE_DIV_EN
        e_lat = XLEN; e_hi = 32'h0000_1234; e_lo = 32'hFFFF_FFFF;
`endif
        chk("divz_lat", lat, e_lat);
        read_hilo(hi, lo);
        chk("divz_hi", hi, e_hi);
        chk("divz_lo", lo, e_lo);

        // DIV most-negative / -1
        do_op(12'h800, 32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 0, lat, res);
`ifdef EXE_DIV_EN
        e_hi = 32'h0000_0000; e_lo = 32'h8000_0000;
`endif
        read_hilo(hi, lo);
        chk("divovf_hi", hi, e_hi);
        chk("divovf_lo", lo, e_lo);

        // MULT then DIV 100 / 3
        do_op(12'h800, 32'hFFFF_FFFF, 32'd2, 3'd1, 0, lat, res);
        do_op(12'h800, 32'd100, 32'd3, 3'd3, 0, lat, res);
`ifdef EXE_DIV_EN
        e_lat = XLEN; e_hi = 32'd1; e_lo = 32'd33;
`else
        e_lat = 0; e_hi = 32'hFFFF_FFFF; e_lo = 32'hFFFF_FFFE;
`endif
        chk("div100_lat", lat, e_lat);
        read_hilo(hi, lo);
        chk("div100_hi", hi, e_hi);
        chk("div100_lo", lo, e_lo);

        // reset pulse during cycle 10 of a MULT
        f_ctrl = 12'h800; f_a = 32'd1234; f_b = 32'd5678; f_md = 3'd1;
        EXE_valid = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_busy_before", EXE_md_busy, 1'b1);
        #1 resetn = 1'b0; EXE_valid = 1'b0;
        #1;
        chk("abort_over_rst", EXE_over, 1'b0);
        chk("abort_busy_rst", EXE_md_busy, 1'b0);
        @(negedge clk);
        #1 resetn = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        read_hilo(hi, lo);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 11);
            ctrl = 12'h800;
            ctrl = ctrl >> k;
            md = 3'($urandom_range(0, 7));
            ra = rnd_val();
            rb = rnd_val();
            extra = $urandom_range(0, 2);
            do_op(ctrl, ra, rb, md, extra, lat, res);
            e_lat = is_multi(md) ? XLEN : 0;
            chk("rand_lat", lat, e_lat);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
